// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO debounce/interrupt front end: register map and defaults.
package gpio_pkg;

    localparam int unsigned WB_AW = 2;
    localparam int unsigned WB_DW = 8;

    localparam logic [WB_AW-1:0] GPIO_DB_FILT = 2'd0;
    localparam logic [WB_AW-1:0] GPIO_DB_RISE = 2'd1;
    localparam logic [WB_AW-1:0] GPIO_DB_FALL = 2'd2;
    localparam logic [WB_AW-1:0] GPIO_DB_STAT = 2'd3;

    localparam int unsigned GPIO_DB_DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/gpio_debounce_irq_if.sv
// Wishbone classic register bus for the GPIO debounce/interrupt block.
interface gpio_debounce_irq_if;
    import gpio_pkg::*;

    logic [WB_AW-1:0] wb_adr_i;
    logic [WB_DW-1:0] wb_dat_i;
    logic             wb_we_i;
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic [2:0]       wb_cti_i;
    logic [1:0]       wb_bte_i;
    logic [WB_DW-1:0] wb_dat_o;
    logic             wb_ack_o;
    logic             wb_err_o;
    logic             wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: two-flop synchroniser, consecutive-sample debounce counter, filtered
// value and single-cycle rise/fall indications for the edge that updates it.
module gpio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned         CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             toggle_c;

    // Toggle happens on the edge where the counter has seen DEBOUNCE_CYCLES differing samples.
    always_comb begin
        toggle_c = (s2 != filt) && (cnt == LAST);
        rise_c   = toggle_c && !filt;
        fall_c   = toggle_c && filt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            filt <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (toggle_c) begin
                cnt  <= '0;
                filt <= ~filt;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_debounce_irq.sv
// GPIO input conditioning: per-bit debounce, edge-enable registers, W1C status and a
// level interrupt, all behind an 8-bit Wishbone classic slave.
module gpio_debounce_irq
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DB_DEBOUNCE_DEFAULT
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic [WIDTH-1:0] gpio_raw_i,
    output logic [WIDTH-1:0] gpio_filt_o,
    output logic             irq_o,
    gpio_debounce_irq_if.slave wb
);

    logic [WIDTH-1:0] rise_c;
    logic [WIDTH-1:0] fall_c;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] set_c;
    logic [WIDTH-1:0] clr_c;
    logic [WB_DW-1:0] rd_data_c;
    logic [WB_DW-1:0] dat_q;
    logic             ack_q;
    logic             req_c;
    logic             wr_c;
    logic             unused_bus;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        gpio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk   (wb_clk),
            .rst   (wb_rst),
            .raw   (gpio_raw_i[i]),
            .filt  (gpio_filt_o[i]),
            .rise_c(rise_c[i]),
            .fall_c(fall_c[i])
        );
    end

    // A new request is only accepted while no ack is outstanding, so held strobes ack every other cycle.
    always_comb begin
        req_c = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
        wr_c  = req_c && wb.wb_we_i;
        set_c = (rise_c & rise_en) | (fall_c & fall_en);
        clr_c = (wr_c && (wb.wb_adr_i == GPIO_DB_STAT)) ? wb.wb_dat_i[WIDTH-1:0] : '0;
    end

    always_comb begin
        rd_data_c = '0;
        case (wb.wb_adr_i)
            GPIO_DB_FILT: rd_data_c = WB_DW'(gpio_filt_o);
            GPIO_DB_RISE: rd_data_c = WB_DW'(rise_en);
            GPIO_DB_FALL: rd_data_c = WB_DW'(fall_en);
            GPIO_DB_STAT: rd_data_c = WB_DW'(status);
            default:      rd_data_c = '0;
        endcase
    end

    // Set has priority over a W1C hitting the same bit on the same edge.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
        end else begin
            ack_q  <= req_c;
            status <= (status & ~clr_c) | set_c;
            if (req_c) begin
                dat_q <= rd_data_c;
            end
            if (wr_c && (wb.wb_adr_i == GPIO_DB_RISE)) begin
                rise_en <= wb.wb_dat_i[WIDTH-1:0];
            end
            if (wr_c && (wb.wb_adr_i == GPIO_DB_FALL)) begin
                fall_en <= wb.wb_dat_i[WIDTH-1:0];
            end
        end
    end

    assign irq_o       = |status;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_err_o = 1'b0;
    assign wb.wb_rty_o = 1'b0;

    // Burst qualifiers and upper data bits carry no meaning for this slave.
    assign unused_bus = ^{wb.wb_cti_i, wb.wb_bte_i, wb.wb_dat_i};

endmodule

// File: tb/tb_gpio_debounce_irq.sv
// Bench for gpio_debounce_irq: register table, directed corner sequences and a random
// phase, all checked cycle by cycle against a windowed behavioural model.
module tb_gpio_debounce_irq;
    import gpio_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] raw = '0;
    logic [W-1:0] filt;
    logic         irq;

    gpio_debounce_irq_if bus();

    gpio_debounce_irq #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .wb_clk     (clk),
        .wb_rst     (rst),
        .gpio_raw_i (raw),
        .gpio_filt_o(filt),
        .irq_o      (irq),
        .wb         (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [W-1:0] m_filt = '0;
    logic [W-1:0] m_rise_en = '0;
    logic [W-1:0] m_fall_en = '0;
    logic [W-1:0] m_status = '0;
    logic         m_ack = 1'b0;
    logic [7:0]   m_dat = '0;
    logic [W-1:0] hist[$];
    int           last_chg[W];
    int           edge_no = 0;

    // hist holds the raw value sampled at each edge; the value seen by the debouncer at
    // edge e is the sample from edge e-2. filt flips when the last D of those seen values
    // all differ from filt and at least D edges have passed since its last change/reset.
    task automatic model_step();
        logic         req;
        logic [7:0]   rd;
        logic [W-1:0] nf, rise, fall, clr;
        edge_no++;
        if (rst) begin
            m_filt = '0; m_rise_en = '0; m_fall_en = '0; m_status = '0;
            m_ack = 1'b0; m_dat = '0;
            hist[hist.size()-1] = '0;
            hist.push_back('0);
            for (int i = 0; i < int'(W); i++) last_chg[i] = edge_no;
        end else begin
            req = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
            case (bus.wb_adr_i)
                2'd0:    rd = m_filt;
                2'd1:    rd = m_rise_en;
                2'd2:    rd = m_fall_en;
                default: rd = m_status;
            endcase
            nf = m_filt; rise = '0; fall = '0;
            for (int i = 0; i < int'(W); i++) begin
                if (edge_no - last_chg[i] >= int'(D)) begin
                    bit all_diff = 1'b1;
                    for (int j = 0; j < int'(D); j++)
                        if (hist[hist.size()-2-j][i] == m_filt[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        nf[i] = ~m_filt[i];
                        if (m_filt[i]) fall[i] = 1'b1; else rise[i] = 1'b1;
                        last_chg[i] = edge_no;
                    end
                end
            end
            clr = (req && bus.wb_we_i && bus.wb_adr_i == 2'd3) ? bus.wb_dat_i : '0;
            m_status = (m_status & ~clr) | (rise & m_rise_en) | (fall & m_fall_en);
            if (req && bus.wb_we_i && bus.wb_adr_i == 2'd1) m_rise_en = bus.wb_dat_i;
            if (req && bus.wb_we_i && bus.wb_adr_i == 2'd2) m_fall_en = bus.wb_dat_i;
            if (req) m_dat = rd;
            m_ack = req;
            m_filt = nf;
            hist.push_back(raw);
        end
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        checks++;
        if (filt !== m_filt || irq !== (|m_status) || bus.wb_ack_o !== m_ack ||
            bus.wb_dat_o !== m_dat || bus.wb_err_o !== 1'b0 || bus.wb_rty_o !== 1'b0) begin
            errors++;
            $display("FAIL model edge=%0d got filt=%h irq=%b ack=%b dat=%h err=%b rty=%b want filt=%h irq=%b ack=%b dat=%h err=0 rty=0",
                     edge_no, filt, irq, bus.wb_ack_o, bus.wb_dat_o, bus.wb_err_o, bus.wb_rty_o,
                     m_filt, |m_status, m_ack, m_dat);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wb_access(input logic [1:0] adr, input logic we, input logic [7:0] dat,
                             output logic [7:0] rd);
        bit got = 1'b0;
        bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = dat;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            if (bus.wb_ack_o === 1'b1) got = 1'b1;
        end
        rd = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        check("wb_ack_timeout", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic [1:0] adr;
        logic       we;
        logic [7:0] wdat;
        logic [7:0] exp;
    } reg_vec_t;

    typedef struct {
        int   len;
        logic exp_pass;
    } pulse_vec_t;

    reg_vec_t   rtab[$];
    pulse_vec_t ptab[$];

    initial begin
        logic [7:0] rd;
        for (int i = 0; i < int'(D) + 2; i++) hist.push_back('0);
        for (int i = 0; i < int'(W); i++) last_chg[i] = 0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;

        // Writes return the pre-write register contents; FILT ignores writes, STATUS is W1C.
        rtab = '{
            '{2'd0, 1'b0, 8'h00, 8'h00}, '{2'd1, 1'b0, 8'h00, 8'h00},
            '{2'd2, 1'b0, 8'h00, 8'h00}, '{2'd3, 1'b0, 8'h00, 8'h00},
            '{2'd1, 1'b1, 8'hA5, 8'h00}, '{2'd1, 1'b0, 8'h00, 8'hA5},
            '{2'd2, 1'b1, 8'h3C, 8'h00}, '{2'd2, 1'b0, 8'h00, 8'h3C},
            '{2'd0, 1'b1, 8'hFF, 8'h00}, '{2'd0, 1'b0, 8'h00, 8'h00},
            '{2'd3, 1'b1, 8'hFF, 8'h00}, '{2'd3, 1'b0, 8'h00, 8'h00},
            '{2'd1, 1'b1, 8'h00, 8'hA5}, '{2'd2, 1'b1, 8'h00, 8'h3C},
            '{2'd1, 1'b0, 8'h00, 8'h00}
        };
        ptab = '{ '{1, 1'b0}, '{2, 1'b0}, '{3, 1'b0}, '{4, 1'b1}, '{6, 1'b1} };

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_filt", 32'(filt), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ack", 32'(bus.wb_ack_o), 32'h0);
        check("rst_dat", 32'(bus.wb_dat_o), 32'h0);

        for (int i = 0; i < rtab.size(); i++) begin
            wb_access(rtab[i].adr, rtab[i].we, rtab[i].wdat, rd);
            check($sformatf("regtab[%0d]", i), 32'(rd), 32'(rtab[i].exp));
        end

        // Clean rising edge on bit 0
        wb_access(GPIO_DB_RISE, 1'b1, 8'h01, rd);
        raw[0] = 1'b1;
        repeat (5) tick();
        check("edge_filt_early", 32'(filt[0]), 32'h0);
        tick();
        check("edge_filt_6cyc", 32'(filt[0]), 32'h1);
        check("edge_irq", 32'(irq), 32'h1);
        wb_access(GPIO_DB_STAT, 1'b0, 8'h00, rd);
        check("edge_status", 32'(rd), 32'h01);
        wb_access(GPIO_DB_STAT, 1'b1, 8'h01, rd);
        raw[0] = 1'b0;
        repeat (8) tick();
        check("edge_fall_no_en", 32'(irq), 32'h0);

        // Glitch shorter than the debounce window
        raw[1] = 1'b1;
        repeat (3) tick();
        raw[1] = 1'b0;
        repeat (10) tick();
        check("glitch_filt", 32'(filt), 32'h00);
        wb_access(GPIO_DB_STAT, 1'b0, 8'h00, rd);
        check("glitch_status", 32'(rd), 32'h00);

        // Pulse-length boundary on bit 4
        for (int p = 0; p < ptab.size(); p++) begin
            bit seen = 1'b0;
            raw[4] = 1'b1;
            for (int t = 0; t < ptab[p].len + 14; t++) begin
                if (t == ptab[p].len) raw[4] = 1'b0;
                tick();
                if (filt[4] === 1'b1) seen = 1'b1;
            end
            check($sformatf("pulse_len%0d", ptab[p].len), 32'(seen), 32'(ptab[p].exp_pass));
            check($sformatf("pulse_len%0d_settle", ptab[p].len), 32'(filt[4]), 32'h0);
        end

        // Masking and W1C on bit 2
        wb_access(GPIO_DB_FALL, 1'b1, 8'h04, rd);
        raw[2] = 1'b1;
        repeat (8) tick();
        wb_access(GPIO_DB_STAT, 1'b0, 8'h00, rd);
        check("mask_rise_ignored", 32'(rd), 32'h00);
        raw[2] = 1'b0;
        repeat (8) tick();
        check("mask_irq", 32'(irq), 32'h1);
        wb_access(GPIO_DB_STAT, 1'b0, 8'h00, rd);
        check("mask_status", 32'(rd), 32'h04);
        wb_access(GPIO_DB_STAT, 1'b1, 8'h04, rd);
        check("w1c_irq_on_ack", 32'(irq), 32'h0);
        wb_access(GPIO_DB_STAT, 1'b0, 8'h00, rd);
        check("w1c_status", 32'(rd), 32'h00);

        // Set wins over a same-edge W1C on bit 0
        raw[0] = 1'b1;
        repeat (5) tick();
        wb_access(GPIO_DB_STAT, 1'b1, 8'h01, rd);
        check("collide_filt", 32'(filt[0]), 32'h1);
        check("collide_irq", 32'(irq), 32'h1);
        wb_access(GPIO_DB_STAT, 1'b0, 8'h00, rd);
        check("collide_status", 32'(rd), 32'h01);

        // Reset during a strobe and during a count
        raw[3] = 1'b1;
        repeat (3) tick();
        bus.wb_adr_i = GPIO_DB_FILT; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        rst = 1'b1;
        tick();
        check("rst_mid_no_ack0", 32'(bus.wb_ack_o), 32'h0);
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        tick();
        check("rst_mid_no_ack1", 32'(bus.wb_ack_o), 32'h0);
        rst = 1'b0;
        tick();
        check("rst_mid_no_ack2", 32'(bus.wb_ack_o), 32'h0);
        repeat (4) tick();
        check("rst_cnt_restart_early", 32'(filt & 8'h09), 32'h00);
        tick();
        check("rst_cnt_restart", 32'(filt & 8'h09), 32'h09);
        check("rst_no_retro_irq", 32'(irq), 32'h0);

        // Random raw activity, bus traffic and occasional resets
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) begin
                int b = int'($urandom_range(W - 1));
                raw[b] = ~raw[b];
            end
            rst = ($urandom_range(399) == 0);
            if (!bus.wb_cyc_i) begin
                if ($urandom_range(3) == 0) begin
                    bus.wb_adr_i = 2'($urandom_range(3));
                    bus.wb_we_i  = 1'($urandom_range(1));
                    bus.wb_dat_i = 8'($urandom);
                    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
                end
            end else if (bus.wb_ack_o === 1'b1 && $urandom_range(1) == 0) begin
                bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
